sp_frame_ctrl: RTL
==================

SP_FRAME_CTRL -- requirements
Module: sp_frame_ctrl

Interface
REQ-001 SHALL have parameter DATADEPTH, default 12, pixel bit width.
REQ-002 SHALL have parameter IMG_WIDTH, default 1920, pixels per line.
REQ-003 SHALL have parameter IMG_HEIGHT, default 1080, lines per frame.
REQ-004 SHALL have parameter HBLANK, default 16, idle cycles between lines (>=1).
REQ-005 SHALL have parameter DRAIN_TO, default 4096, max cycles between en_i pulses in drain before error.
REQ-006 SHALL derive ADDR_W = clog2(IMG_WIDTH*IMG_HEIGHT).
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 start  in  1  one-cycle request to stream one frame.
REQ-010 abort  in  1  synchronous cancel of current frame.
REQ-011 mem_rd  out  1  frame memory read strobe.
REQ-012 mem_addr  out  ADDR_W  frame memory pixel address.
REQ-013 mem_data  in  DATADEPTH  read data, valid exactly 1 cycle after mem_rd.
REQ-014 vsync  out  1  frame-start strobe to filter.
REQ-015 hsync  out  1  line-start strobe to filter.
REQ-016 pix_o  out  DATADEPTH  pixel to filter data_i.
REQ-017 pix_valid  out  1  pix_o valid.
REQ-018 en_i  in  1  filter output-valid (en_o of filter).
REQ-019 busy  out  1  high from accepted start until return to IDLE.
REQ-020 done  out  1  one-cycle pulse on frame completion.
REQ-021 err  out  1  one-cycle pulse on drain timeout.

Function
REQ-022 SHALL implement FSM states IDLE, ACTIVE, HBLK, DRAIN, DONE.
REQ-023 IDLE: start=1 -> ACTIVE, address counter cleared to 0, output counter cleared; start in any other state ignored.
REQ-024 ACTIVE: mem_rd=1 every cycle, mem_addr increments by 1 per cycle from 0; after IMG_WIDTH reads -> HBLK, or -> DRAIN if line IMG_HEIGHT-1 just finished.
REQ-025 HBLK: mem_rd=0 for exactly HBLANK cycles, then -> ACTIVE; no HBLK after the last line.
REQ-026 pix_o <= mem_data and pix_valid <= registered mem_rd, i.e. pixel outputs lag mem_rd by exactly 1 cycle.
REQ-027 hsync SHALL be 1 in the same cycle as pix_valid for column 0 of every line, else 0.
REQ-028 vsync SHALL be 1 only with pix_valid for pixel (0,0), else 0.
REQ-029 SHALL count en_i pulses while busy (ACTIVE, HBLK, DRAIN), saturating at IMG_WIDTH*IMG_HEIGHT.
REQ-030 DRAIN: count reaching IMG_WIDTH*IMG_HEIGHT -> DONE; DRAIN_TO consecutive cycles without en_i -> IDLE with err=1 for one cycle.
REQ-031 DONE: done=1 for one cycle, -> IDLE.
REQ-032 busy=1 in ACTIVE, HBLK, DRAIN, DONE; 0 in IDLE.
REQ-033 abort=1 in any non-IDLE state -> IDLE next cycle, mem_rd=0 immediately from that cycle, pix_valid=0 one cycle later, no done, no err; abort has priority over all other transitions.
REQ-034 start and abort together in IDLE: abort wins, stays IDLE.
REQ-035 en_i in IDLE SHALL be ignored (not counted).
REQ-036 mem_addr SHALL hold last value when mem_rd=0; never exceed IMG_WIDTH*IMG_HEIGHT-1.

Reset
REQ-037 rst_n=0 SHALL force immediately: state IDLE, mem_rd=0, mem_addr=0, vsync=0, hsync=0, pix_o=0, pix_valid=0, busy=0, done=0, err=0, all counters 0.
REQ-038 Reset mid-frame SHALL discard frame with no done/err pulse; first start after release begins at address 0.

Verification (IMG_WIDTH=8, IMG_HEIGHT=4, HBLANK=2, DRAIN_TO=16, mem_data=address)
REQ-039 start pulse, en_i echoes pix_valid delayed 3 cycles -> 32 mem_rd cycles (addresses 0..31), 3 HBLK gaps of 2 cycles, pix_o = 0..31, done pulse once, busy low after.
REQ-040 Same run -> vsync high exactly once (with pix_o=0); hsync high 4 times (with pix_o=0,8,16,24).
REQ-041 en_i held 0 -> after last pixel, err pulses 16 cycles into DRAIN, done never asserted, busy drops.
REQ-042 abort at address 12 -> mem_rd low next cycle, IDLE, no done/err; new start streams from address 0.
REQ-043 start while busy and start+abort in IDLE -> no effect, busy unchanged.
REQ-044 rst_n low during HBLK of line 1 -> all outputs 0 asynchronously; subsequent start completes normal frame.

Source files
------------

// File: rtl/sp_frame_ctrl_if.sv
// Frame controller signal bundle: host control, frame-memory read port and filter stream.
interface sp_frame_ctrl_if #(
  parameter int DATADEPTH = 12,
  parameter int ADDR_W    = 21
);
  logic                 start;
  logic                 abort;
  logic                 mem_rd;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATADEPTH-1:0] mem_data;
  logic                 vsync;
  logic                 hsync;
  logic [DATADEPTH-1:0] pix_o;
  logic                 pix_valid;
  logic                 en_i;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport slave (
    input  start, abort, mem_data, en_i,
    output mem_rd, mem_addr, vsync, hsync, pix_o, pix_valid, busy, done, err
  );

  modport master (
    output start, abort, mem_data, en_i,
    input  mem_rd, mem_addr, vsync, hsync, pix_o, pix_valid, busy, done, err
  );
endinterface

// File: rtl/sp_frame_ctrl.sv
// Streams one frame from frame memory to a filter, line by line with horizontal blanking,
// then waits for the filter to return every pixel before signalling done (or err on stall).
module sp_frame_ctrl #(
  parameter int DATADEPTH  = 12,
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080,
  parameter int HBLANK     = 16,
  parameter int DRAIN_TO   = 4096,
  localparam int NPIX      = IMG_WIDTH * IMG_HEIGHT,
  localparam int ADDR_W    = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input logic clk,
  input logic rst_n,
  sp_frame_ctrl_if.slave bus
);
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int LW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int HW = (HBLANK     > 1) ? $clog2(HBLANK)     : 1;
  localparam int OW = $clog2(NPIX + 1);
  localparam int TW = $clog2(DRAIN_TO + 1);

  typedef enum logic [2:0] {S_IDLE, S_ACTIVE, S_HBLK, S_DRAIN, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [CW-1:0]       r_col;
  logic [LW-1:0]       r_line;
  logic [HW-1:0]       r_hcnt;
  logic [OW-1:0]       r_ocnt, w_ocnt_nxt;
  logic [TW-1:0]       r_tocnt;
  logic                r_pv, r_hs, r_vs, r_err;
  logic                w_mem_rd, w_last_col, w_last_line, w_hblk_end, w_timeout;
  logic                w_clr, w_err_nxt, w_counting;

  assign w_last_col  = (r_col  == CW'(IMG_WIDTH - 1));
  assign w_last_line = (r_line == LW'(IMG_HEIGHT - 1));
  assign w_hblk_end  = (r_hcnt == HW'(HBLANK - 1));
  assign w_mem_rd    = (r_state == S_ACTIVE) && !bus.abort;
  assign w_counting  = (r_state == S_ACTIVE) || (r_state == S_HBLK) || (r_state == S_DRAIN);
  assign w_timeout   = (r_state == S_DRAIN) && !bus.en_i && (r_tocnt == TW'(DRAIN_TO - 1));

  // returned-pixel count saturates so stray en_i pulses cannot wrap it
  always_comb begin
    w_ocnt_nxt = r_ocnt;
    if (w_counting && bus.en_i && (r_ocnt != OW'(NPIX)))
      w_ocnt_nxt = r_ocnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_err_nxt   = 1'b0;
    if (bus.abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (bus.start) begin
                    w_state_nxt = S_ACTIVE;
                    w_clr       = 1'b1;
                  end
        S_ACTIVE: if (w_last_col) w_state_nxt = w_last_line ? S_DRAIN : S_HBLK;
        S_HBLK:   if (w_hblk_end) w_state_nxt = S_ACTIVE;
        S_DRAIN:  if (w_ocnt_nxt == OW'(NPIX)) begin
                    w_state_nxt = S_DONE;
                  end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                  end
        S_DONE:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // address holds on the final pixel so it never runs past the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_col   <= '0;
      r_line  <= '0;
      r_hcnt  <= '0;
      r_ocnt  <= '0;
      r_tocnt <= '0;
      r_pv    <= 1'b0;
      r_hs    <= 1'b0;
      r_vs    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_clr) begin
        r_addr <= '0;
        r_col  <= '0;
        r_line <= '0;
      end else if (w_mem_rd) begin
        if (!(w_last_col && w_last_line)) r_addr <= r_addr + 1'b1;
        r_col <= w_last_col ? '0 : r_col + 1'b1;
        if (w_last_col && !w_last_line) r_line <= r_line + 1'b1;
      end

      if ((r_state == S_HBLK) && !bus.abort) r_hcnt <= w_hblk_end ? '0 : r_hcnt + 1'b1;
      else                                   r_hcnt <= '0;

      r_ocnt <= w_clr ? '0 : w_ocnt_nxt;

      if ((r_state == S_DRAIN) && !bus.en_i && !bus.abort) r_tocnt <= r_tocnt + 1'b1;
      else                                                 r_tocnt <= '0;

      r_pv  <= w_mem_rd;
      r_hs  <= w_mem_rd && (r_col == '0);
      r_vs  <= w_mem_rd && (r_col == '0) && (r_line == '0);
      r_err <= w_err_nxt;
    end
  end

  // memory returns data the cycle after the read, aligned with r_pv
  assign bus.mem_rd    = w_mem_rd;
  assign bus.mem_addr  = r_addr;
  assign bus.pix_o     = r_pv ? bus.mem_data : '0;
  assign bus.pix_valid = r_pv;
  assign bus.hsync     = r_hs;
  assign bus.vsync     = r_vs;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE) && !bus.abort;
  assign bus.err       = r_err;

endmodule
